// File: rtl/imm_gen_arbiter_if.sv
// Bus bundle between the imm_gen_arbiter, its two requesters, the ImmGenUnit
// and the result consumer. The slave modport is the arbiter's view.
interface imm_gen_arbiter_if #(
  parameter int unsigned WORD_LENGTH = 24,
  parameter int unsigned TAG_W       = 4
);
  logic                   req0_valid;
  logic [WORD_LENGTH-1:0] req0_instr;
  logic [TAG_W-1:0]       req0_tag;
  logic                   req0_ready;

  logic                   req1_valid;
  logic [WORD_LENGTH-1:0] req1_instr;
  logic [TAG_W-1:0]       req1_tag;
  logic                   req1_ready;

  logic [WORD_LENGTH-1:0] imm_instr;
  logic [WORD_LENGTH-1:0] imm_y;

  logic                   res_valid;
  logic [WORD_LENGTH-1:0] res_data;
  logic                   res_src;
  logic [TAG_W-1:0]       res_tag;
  logic                   res_ready;

  modport slave (
    input  req0_valid, req0_instr, req0_tag,
    input  req1_valid, req1_instr, req1_tag,
    input  imm_y, res_ready,
    output req0_ready, req1_ready, imm_instr,
    output res_valid, res_data, res_src, res_tag
  );

  modport master (
    output req0_valid, req0_instr, req0_tag,
    output req1_valid, req1_instr, req1_tag,
    output imm_y, res_ready,
    input  req0_ready, req1_ready, imm_instr,
    input  res_valid, res_data, res_src, res_tag
  );
endinterface

// File: rtl/imm_gen_arbiter.sv
// imm_gen_arbiter: shares one combinational ImmGenUnit between the decode
// pipeline (requester 0, fixed priority) and a diagnostic port (requester 1,
// protected by an anti-starvation counter). The immediate is captured in a
// one-deep valid/ready output stage.
// Optional grant/stall statistics counters: define IMM_ARB_STATS_EN.
module imm_gen_arbiter #(
  parameter int unsigned WORD_LENGTH = 24,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned STARVE_MAX  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  imm_gen_arbiter_if.slave    bus
`ifdef IMM_ARB_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [15:0]         stat_cnt0,
  output logic [15:0]         stat_cnt1,
  output logic [15:0]         stat_stall
`endif
);

  localparam int unsigned CNT_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic                   res_valid_q;
  logic [WORD_LENGTH-1:0] res_data_q;
  logic                   res_src_q;
  logic [TAG_W-1:0]       res_tag_q;
  logic [CNT_W-1:0]       starve_cnt;

  logic                   can_accept_c;
  logic                   grant0_c;
  logic                   grant1_c;
  logic [WORD_LENGTH-1:0] imm_instr_c;

  // Arbitration: requester 1 wins when forced by starvation or uncontested.
  always_comb begin
    can_accept_c = !res_valid_q || bus.res_ready;
    grant1_c     = 1'b0;
    grant0_c     = 1'b0;
    imm_instr_c  = '0;
    if (rst_n && can_accept_c) begin
      if (bus.req1_valid && ((starve_cnt == STARVE_LIM) || !bus.req0_valid)) begin
        grant1_c = 1'b1;
      end else if (bus.req0_valid) begin
        grant0_c = 1'b1;
      end
    end
    if (grant1_c) begin
      imm_instr_c = bus.req1_instr;
    end else if (grant0_c) begin
      imm_instr_c = bus.req0_instr;
    end
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;
  assign bus.imm_instr  = imm_instr_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_src    = res_src_q;
  assign bus.res_tag    = res_tag_q;

  // Output stage: capture on grant, drain when consumed, hold under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_src_q   <= 1'b0;
      res_tag_q   <= '0;
    end else if (grant0_c || grant1_c) begin
      res_valid_q <= 1'b1;
      res_data_q  <= bus.imm_y;
      res_src_q   <= grant1_c;
      res_tag_q   <= grant1_c ? bus.req1_tag : bus.req0_tag;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  // Lost-arbitration counter for requester 1; frozen while the stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (can_accept_c) begin
      if (grant1_c || !bus.req1_valid) begin
        starve_cnt <= '0;
      end else if (starve_cnt < STARVE_LIM) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

`ifdef IMM_ARB_STATS_EN
  logic stall_c;

  // A stall is a cycle where someone is asking but the stage cannot accept.
  always_comb begin
    stall_c = (bus.req0_valid || bus.req1_valid) && !can_accept_c;
  end

  // Saturating statistics; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt0  <= '0;
      stat_cnt1  <= '0;
      stat_stall <= '0;
    end else if (stat_clr) begin
      stat_cnt0  <= '0;
      stat_cnt1  <= '0;
      stat_stall <= '0;
    end else begin
      if (grant0_c && (stat_cnt0 != 16'hFFFF)) stat_cnt0 <= stat_cnt0 + 16'd1;
      if (grant1_c && (stat_cnt1 != 16'hFFFF)) stat_cnt1 <= stat_cnt1 + 16'd1;
      if (stall_c && (stat_stall != 16'hFFFF)) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_arbiter.sv
// Self-checking bench for imm_gen_arbiter: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a model.
module tb_imm_gen_arbiter;
  localparam int unsigned WL   = 24;
  localparam int unsigned TW   = 4;
  localparam int unsigned SMAX = 3;
  localparam logic [23:0] IMM_KEY = 24'hA5A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_arbiter_if #(.WORD_LENGTH(WL), .TAG_W(TW)) bus ();

  // ImmGenUnit stand-in
  assign bus.imm_y = bus.imm_instr ^ IMM_KEY;

`ifdef IMM_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_cnt0, stat_cnt1, stat_stall;
`endif

  imm_gen_arbiter #(.WORD_LENGTH(WL), .TAG_W(TW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IMM_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_cnt0  (stat_cnt0),
    .stat_cnt1  (stat_cnt1),
    .stat_stall (stat_stall)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic        m_valid;
  logic [23:0] m_data;
  logic        m_src;
  logic [3:0]  m_tag;
  int          m_lost;
  int          m_c0, m_c1, m_st;

  initial begin
    bit acc, g0, g1;
    logic [23:0] exp_instr;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_tag = '0; m_lost = 0;
        m_c0 = 0; m_c1 = 0; m_st = 0;
        chk("rst_res_valid", 32'(bus.res_valid), 32'(0));
        chk("rst_res_data",  32'(bus.res_data), 32'(0));
        chk("rst_ready0",    32'(bus.req0_ready), 32'(0));
        chk("rst_ready1",    32'(bus.req1_ready), 32'(0));
        chk("rst_imm_instr", 32'(bus.imm_instr), 32'(0));
        continue;
      end
      chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
      chk("res_data",  32'(bus.res_data),  32'(m_data));
      chk("res_src",   32'(bus.res_src),   32'(m_src));
      chk("res_tag",   32'(bus.res_tag),   32'(m_tag));
      chk("starve_cnt", 32'(dut.starve_cnt), 32'(m_lost));
`ifdef IMM_ARB_STATS_EN
      chk("stat_cnt0",  32'(stat_cnt0),  32'(m_c0));
      chk("stat_cnt1",  32'(stat_cnt1),  32'(m_c1));
      chk("stat_stall", 32'(stat_stall), 32'(m_st));
`endif
      acc = !m_valid || bus.res_ready;
      g1  = acc && bus.req1_valid && (m_lost == SMAX || !bus.req0_valid);
      g0  = acc && !g1 && bus.req0_valid;
      exp_instr = g1 ? bus.req1_instr : (g0 ? bus.req0_instr : 24'h0);
      chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
      chk("imm_instr",  32'(bus.imm_instr),  32'(exp_instr));
`ifdef IMM_ARB_STATS_EN
      if (stat_clr) begin
        m_c0 = 0; m_c1 = 0; m_st = 0;
      end else begin
        if (g0 && m_c0 < 65535) m_c0++;
        if (g1 && m_c1 < 65535) m_c1++;
        if ((bus.req0_valid || bus.req1_valid) && !acc && m_st < 65535) m_st++;
      end
`endif
      if (g0 || g1) begin
        m_valid = 1'b1;
        m_data  = exp_instr ^ IMM_KEY;
        m_src   = g1;
        m_tag   = g1 ? bus.req1_tag : bus.req0_tag;
      end else if (bus.res_ready) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        if (g1 || !bus.req1_valid) m_lost = 0;
        else if (m_lost < SMAX) m_lost++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] exp_s [4];
    bit          exp_g [8];
    int          exp_sc [8];
    bit          r0, r1;
    exp_s  = '{24'hA5A5A4, 24'hA5A5A7, 24'hA5A5A6, 24'hA5A5A1};
    exp_g  = '{0, 0, 0, 1, 0, 0, 0, 1};
    exp_sc = '{0, 1, 2, 3, 0, 1, 2, 3};

    bus.req0_valid = 0; bus.req0_instr = '0; bus.req0_tag = '0;
    bus.req1_valid = 0; bus.req1_instr = '0; bus.req1_tag = '0;
    bus.res_ready  = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First transaction after reset
    bus.req0_valid = 1; bus.req0_instr = 24'h123456; bus.req0_tag = 4'd3; bus.res_ready = 1;
    @(negedge clk);
    chk("first_ready0", 32'(bus.req0_ready), 32'(1));
    to_drive();
    bus.req0_valid = 0;
    chk("first_valid", 32'(bus.res_valid), 32'(1));
    chk("first_data",  32'(bus.res_data),  32'h00B791F3);
    chk("first_src",   32'(bus.res_src),   32'(0));
    chk("first_tag",   32'(bus.res_tag),   32'(3));
    to_drive();

    // Streaming, one result per cycle
    bus.req0_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.req0_instr = 24'(i + 1);
      bus.req0_tag   = 4'(i + 4);
      @(negedge clk);
      chk("stream_ready0", 32'(bus.req0_ready), 32'(1));
      to_drive();
      chk("stream_valid", 32'(bus.res_valid), 32'(1));
      chk("stream_data",  32'(bus.res_data),  32'(exp_s[i]));
      chk("stream_src",   32'(bus.res_src),   32'(0));
    end
    bus.req0_valid = 0;

    // Asynchronous reset while a result is held
    bus.res_ready = 0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.res_valid), 32'(0));
    chk("async_rst_data",  32'(bus.res_data),  32'(0));
    chk("async_rst_tag",   32'(bus.res_tag),   32'(0));
    to_drive();
    rst_n = 1'b1;

    // Starvation: both requesters continuously valid
    bus.req0_valid = 1; bus.req0_instr = 24'h000F0F; bus.req0_tag = 4'd1;
    bus.req1_valid = 1; bus.req1_instr = 24'h0F0F00; bus.req1_tag = 4'd2;
    bus.res_ready  = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("starve_grant1", 32'(bus.req1_ready), 32'(exp_g[k]));
      chk("starve_grant0", 32'(bus.req0_ready), 32'(!exp_g[k]));
      chk("starve_seq",    32'(dut.starve_cnt), 32'(exp_sc[k]));
      to_drive();
    end
`ifdef IMM_ARB_STATS_EN
    chk("stats_cnt0_8", 32'(stat_cnt0), 32'(6));
    chk("stats_cnt1_8", 32'(stat_cnt1), 32'(2));
    stat_clr = 1'b1;
`endif
    @(negedge clk);
    chk("clr_cycle_grant0", 32'(bus.req0_ready), 32'(1));
    to_drive();
`ifdef IMM_ARB_STATS_EN
    stat_clr = 1'b0;
    chk("stats_clr_cnt0",  32'(stat_cnt0),  32'(0));
    chk("stats_clr_cnt1",  32'(stat_cnt1),  32'(0));
    chk("stats_clr_stall", 32'(stat_stall), 32'(0));
`endif

    // Back-pressure: result held, nobody granted, counter frozen at 1
    bus.res_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready0", 32'(bus.req0_ready), 32'(0));
      chk("bp_ready1", 32'(bus.req1_ready), 32'(0));
      chk("bp_data",   32'(bus.res_data),   32'(24'h000F0F ^ IMM_KEY));
      chk("bp_starve", 32'(dut.starve_cnt), 32'(1));
      to_drive();
    end
`ifdef IMM_ARB_STATS_EN
    chk("stats_stall5", 32'(stat_stall), 32'(5));
`endif
    bus.res_ready = 1;
    @(negedge clk);
    chk("bp_release_grant0", 32'(bus.req0_ready), 32'(1));
    to_drive();
    bus.req0_valid = 0; bus.req1_valid = 0;
    to_drive();

    // Idle requester 0: requester 1 granted immediately
    bus.req1_valid = 1; bus.req1_instr = 24'hFFFFFF; bus.req1_tag = 4'd9;
    @(negedge clk);
    chk("idle_ready1",    32'(bus.req1_ready), 32'(1));
    chk("idle_imm_instr", 32'(bus.imm_instr),  32'h00FFFFFF);
    to_drive();
    bus.req1_valid = 0;
    chk("idle_data", 32'(bus.res_data), 32'h005A5A5A);
    chk("idle_src",  32'(bus.res_src),  32'(1));
    chk("idle_tag",  32'(bus.res_tag),  32'(9));
    @(negedge clk);
    chk("nogrant_imm_instr", 32'(bus.imm_instr), 32'(0));
    to_drive();

    // Randomized traffic with back-pressure, stat clears and a reset pulse
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      to_drive();
      if (!bus.req0_valid || r0) begin
        bus.req0_valid = ($urandom_range(0, 99) < 60);
        bus.req0_instr = 24'($urandom);
        bus.req0_tag   = 4'($urandom);
      end
      if (!bus.req1_valid || r1) begin
        bus.req1_valid = ($urandom_range(0, 99) < 45);
        bus.req1_instr = 24'($urandom);
        bus.req1_tag   = 4'($urandom);
      end
      bus.res_ready = ($urandom_range(0, 99) < 70);
`ifdef IMM_ARB_STATS_EN
      stat_clr = ($urandom_range(0, 99) < 3);
`endif
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
